// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser: FSM states, abort causes
// and the default header bytes.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H1,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles, saturates at TIMEOUT and
// flags expiry while the count sits at the limit.
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // A byte arriving in the expiry cycle clears the counter and suppresses the flag.
  assign expired = en && !clr && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 CMD LEN payload CHK frames from the UART byte stream,
// streams payload bytes and reports each frame as done or aborted.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HDR0    = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1    = HDR1_DEFAULT,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Data_Byte,
  input  logic       Rx_Done,
  output logic [7:0] Cmd,
  output logic [7:0] Len,
  output logic [7:0] Pay_Data,
  output logic       Pay_Valid,
  output logic [7:0] Pay_Idx,
  output logic       Frame_Done,
  output logic       Frame_Err,
  output logic [1:0] Err_Code,
  output logic       Busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] xor_q, xor_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] pay_data_q, pay_data_d;
  logic [7:0] pay_idx_q, pay_idx_d;
  logic       pay_valid_q, pay_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       tmo_expired;

  uart_byte_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (Clk),
    .rst_n   (Rst),
    .en      (state_q != S_IDLE),
    .clr     (Rx_Done),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    xor_d        = xor_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    pay_data_d   = pay_data_q;
    pay_idx_d    = pay_idx_q;
    pay_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;

    if (Rx_Done) begin
      case (state_q)
        S_IDLE: begin
          if (Data_Byte == HDR0) state_d = S_H1;
        end
        S_H1: begin
          if (Data_Byte == HDR1)      state_d = S_CMD;
          else if (Data_Byte == HDR0) state_d = S_H1;
          else                        state_d = S_IDLE;
        end
        S_CMD: begin
          cmd_d   = Data_Byte;
          xor_d   = Data_Byte;
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = Data_Byte;
          xor_d = xor_q ^ Data_Byte;
          cnt_d = '0;
          if (Data_Byte > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else if (Data_Byte == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          pay_data_d  = Data_Byte;
          pay_valid_d = 1'b1;
          pay_idx_d   = cnt_q;
          xor_d       = xor_q ^ Data_Byte;
          cnt_d       = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == len_q) state_d = S_CHK;
        end
        S_CHK: begin
          if (Data_Byte == xor_q) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_expired) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      xor_q        <= '0;
      cnt_q        <= '0;
      cmd_q        <= '0;
      len_q        <= '0;
      pay_data_q   <= '0;
      pay_idx_q    <= '0;
      pay_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      xor_q        <= xor_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      len_q        <= len_d;
      pay_data_q   <= pay_data_d;
      pay_idx_q    <= pay_idx_d;
      pay_valid_q  <= pay_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign Cmd        = cmd_q;
  assign Len        = len_q;
  assign Pay_Data   = pay_data_q;
  assign Pay_Valid  = pay_valid_q;
  assign Pay_Idx    = pay_idx_q;
  assign Frame_Done = frame_done_q;
  assign Frame_Err  = frame_err_q;
  assign Err_Code   = err_code_q;
  assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus random
// streams compared against an index-based frame model.
module tb_uart_frame_parser;

  localparam int unsigned TMO  = 200;
  localparam int unsigned MAXL = 32;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] Data_Byte = 8'h00;
  logic       Rx_Done = 1'b0;
  logic [7:0] Cmd, Len, Pay_Data, Pay_Idx;
  logic       Pay_Valid, Frame_Done, Frame_Err, Busy;
  logic [1:0] Err_Code;

  uart_frame_parser #(
    .HDR0    (8'hAA),
    .HDR1    (8'h55),
    .MAX_LEN (MAXL),
    .TIMEOUT (TMO)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Data_Byte  (Data_Byte),
    .Rx_Done    (Rx_Done),
    .Cmd        (Cmd),
    .Len        (Len),
    .Pay_Data   (Pay_Data),
    .Pay_Valid  (Pay_Valid),
    .Pay_Idx    (Pay_Idx),
    .Frame_Done (Frame_Done),
    .Frame_Err  (Frame_Err),
    .Err_Code   (Err_Code),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // kind 0 = payload {data, idx}, 1 = done {cmd, len}, 2 = error {code, 0}
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;
  typedef logic [7:0] byte_q_t[$];

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  overlap_seen = 1'b0;

  always @(negedge Clk) begin
    if (Rst) begin
      if (Pay_Valid)  obs_q.push_back(ev_t'({2'd0, Pay_Data, Pay_Idx}));
      if (Frame_Done) obs_q.push_back(ev_t'({2'd1, Cmd, Len}));
      if (Frame_Err)  obs_q.push_back(ev_t'({2'd2, 6'd0, Err_Code, 8'd0}));
      if ((Frame_Done && Frame_Err) || (Pay_Valid && (Frame_Done || Frame_Err)))
        overlap_seen = 1'b1;
    end
  end

  function automatic ev_t mk_ev(input logic [1:0] kind, input logic [7:0] a, input logic [7:0] b);
    return ev_t'({kind, a, b});
  endfunction

  // Reference: find the first AA 55 pair, slice out CMD/LEN/payload/CHK by index.
  // A stream ending inside a frame (or on a lone AA) means the watchdog fires.
  function automatic void build_model(input byte_q_t s);
    int unsigned n, i, j, len;
    logic [7:0] x;
    exp_q.delete();
    n = s.size();
    i = 0;
    while (i < n) begin
      if (s[i] != 8'hAA) begin i++; continue; end
      if (i + 1 >= n) begin exp_q.push_back(mk_ev(2'd2, 8'd3, 8'd0)); return; end
      if (s[i+1] != 8'h55) begin i++; continue; end
      j = i + 2;
      if (j + 1 >= n) begin exp_q.push_back(mk_ev(2'd2, 8'd3, 8'd0)); return; end
      len = int'(s[j+1]);
      if (len > MAXL) begin
        exp_q.push_back(mk_ev(2'd2, 8'd2, 8'd0));
        i = j + 2;
        continue;
      end
      x = s[j] ^ s[j+1];
      for (int unsigned k = 0; k < len; k++) begin
        if (j + 2 + k >= n) begin exp_q.push_back(mk_ev(2'd2, 8'd3, 8'd0)); return; end
        exp_q.push_back(mk_ev(2'd0, s[j+2+k], 8'(k)));
        x = x ^ s[j+2+k];
      end
      if (j + 2 + len >= n) begin exp_q.push_back(mk_ev(2'd2, 8'd3, 8'd0)); return; end
      if (s[j+2+len] == x) exp_q.push_back(mk_ev(2'd1, s[j], s[j+1]));
      else                 exp_q.push_back(mk_ev(2'd2, 8'd1, 8'd0));
      i = j + 3 + len;
    end
  endfunction

  // Entered and left one time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    Data_Byte = b;
    Rx_Done   = 1'b1;
    @(posedge Clk); #1;
    Rx_Done   = 1'b0;
    Data_Byte = 8'($urandom);
    repeat (gap) begin @(posedge Clk); #1; end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic send_stream(input byte_q_t s, input int unsigned max_gap);
    foreach (s[k]) send_byte(s[k], $urandom_range(max_gap, 0));
    idle(TMO + 10);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    checks++;
    if ({Cmd, Len, Pay_Data, Pay_Valid, Pay_Idx, Frame_Done, Frame_Err, Err_Code, Busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {Cmd, Len, Pay_Data, Pay_Valid, Pay_Idx, Frame_Done, Frame_Err, Err_Code, Busy});
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    byte_q_t s;
    s = '{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
    build_model(s);
    obs_q.delete();
    send_stream(s, 2);
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL good_count: got %0d events expected 4", obs_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL good_ev%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (Cmd !== 8'h10 || Len !== 8'h03) begin
      errors++; $display("FAIL good_cmd_len: got %h/%h expected 10/03", Cmd, Len);
    end
  endtask

  task automatic test_bad_checksum();
    byte_q_t s;
    s = '{8'hAA, 8'h55, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14};
    build_model(s);
    obs_q.delete();
    send_stream(s, 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL chk_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL chk_ev%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (Err_Code !== 2'd1) begin
      errors++; $display("FAIL chk_code: got %0d expected 1", Err_Code);
    end
  endtask

  task automatic test_length();
    byte_q_t s;
    s = '{8'hAA, 8'h55, 8'h07, 8'h21, 8'hAA, 8'h55, 8'h07, 8'h00, 8'h07};
    build_model(s);
    obs_q.delete();
    send_stream(s, 1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL len_count: got %0d events expected 2", obs_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL len_ev%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (Err_Code !== 2'd2) begin
      errors++; $display("FAIL len_code_held: got %0d expected 2", Err_Code);
    end
  endtask

  task automatic test_timeout();
    byte_q_t s;
    int unsigned hit;
    s = '{8'hAA, 8'h55, 8'h07, 8'h02, 8'h01};
    hit = 0;
    build_model(s);
    obs_q.delete();
    foreach (s[k]) send_byte(s[k], 0);
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL tmo_busy_mid: got %b expected 1", Busy);
    end
    for (int unsigned c = 1; c <= TMO + 10; c++) begin
      @(posedge Clk); #1;
      if (Frame_Err && hit == 0) hit = c;
    end
    checks++;
    if (hit != TMO + 1) begin
      errors++; $display("FAIL tmo_latency: got %0d cycles expected %0d", hit, TMO + 1);
    end
    checks++;
    if (Busy !== 1'b0 || Err_Code !== 2'd3) begin
      errors++; $display("FAIL tmo_state: got busy=%b code=%0d expected busy=0 code=3", Busy, Err_Code);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tmo_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL tmo_ev%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  // A gap of exactly TMO lands the byte in the expiry cycle (byte wins); one more cycle aborts.
  task automatic test_timeout_boundary();
    for (int unsigned g = TMO; g <= TMO + 1; g++) begin
      exp_q.delete();
      if (g == TMO) begin
        exp_q.push_back(mk_ev(2'd0, 8'h09, 8'd0));
        exp_q.push_back(mk_ev(2'd1, 8'h07, 8'h01));
      end else begin
        exp_q.push_back(mk_ev(2'd2, 8'd3, 8'd0));
      end
      obs_q.delete();
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      send_byte(8'h07, 0);
      send_byte(8'h01, g);
      send_byte(8'h09, 0);
      send_byte(8'h0F, 4);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL tmo_edge_count(gap %0d): got %0d expected %0d", g, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < obs_q.size()) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL tmo_edge_ev%0d(gap %0d): got %h expected %h", k, g, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_resync();
    byte_q_t s;
    s = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h05, 8'h00, 8'h05};
    build_model(s);
    obs_q.delete();
    send_stream(s, 0);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL resync_count: got %0d events expected 1", obs_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL resync_ev%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t s;
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h10, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    Rst = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      checks++;
      if ({Cmd, Len, Pay_Data, Pay_Valid, Pay_Idx, Frame_Done, Frame_Err, Err_Code, Busy} !== '0) begin
        errors++;
        $display("FAIL midrst_outputs: got %h expected 0",
                 {Cmd, Len, Pay_Data, Pay_Valid, Pay_Idx, Frame_Done, Frame_Err, Err_Code, Busy});
      end
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    idle(1);
    s = '{8'hAA, 8'h55, 8'h22, 8'h02, 8'h5A, 8'hC3, 8'hBA};
    build_model(s);
    obs_q.delete();
    send_stream(s, 1);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL midrst_count: got %0d events expected 3", obs_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL midrst_ev%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    byte_q_t s;
    logic [7:0] x, cmd, len;
    for (int unsigned it = 0; it < 10; it++) begin
      s.delete();
      for (int unsigned f = 0; f < 3; f++) begin
        repeat ($urandom_range(2, 0)) s.push_back(8'($urandom));
        cmd = 8'($urandom);
        len = 8'($urandom_range(36, 0));
        s.push_back(8'hAA);
        s.push_back(8'h55);
        s.push_back(cmd);
        s.push_back(len);
        x = cmd ^ len;
        for (int unsigned k = 0; k < len; k++) begin
          s.push_back(8'($urandom));
          x = x ^ s[s.size()-1];
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        s.push_back(x);
      end
      if ($urandom_range(7, 0) == 0) void'(s.pop_back());
      build_model(s);
      obs_q.delete();
      send_stream(s, 3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d events expected %0d", it, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < obs_q.size()) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand%0d_ev%0d: got %h expected %h", it, k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++; $display("FAIL strobe_overlap: got %b expected 0", overlap_seen);
    end
  endtask

  initial begin
    @(posedge Clk); #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_timeout_boundary();
    test_resync();
    test_reset_mid_frame();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
